mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 270 +++++++++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one backend memory port between an instruction fetch
// port (2-entry in-order address FIFO) and a data load/store port (1-entry
// slot). Only one backend access is in flight at a time.
// Compile-time option MEMARB_RR_EN: when defined, conflicts are resolved
// round-robin; when undefined, the data side wins every conflict.
//
// state | meaning
// IDLE  | no access in flight, choosing the next side to serve
// IREQ  | fetch presented on bus_*, waiting for bus_ready
// DREQ  | data access presented on bus_*, waiting for bus_ready
// IWAIT | fetch accepted, waiting for bus_valid
// DWAIT | data read accepted, waiting for bus_valid
module mem_arbiter #(
    parameter logic [31:0] BOOT_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] imem_addr,
    input  logic        imem_oe,
    output logic [31:0] imem_rdata,
    output logic        imem_valid,
    input  logic [31:0] mem_addr,
    input  logic [3:0]  mem_oe,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_we,
    output logic [31:0] mem_rdata,
    output logic        mem_valid,
    output logic        mem_ready,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_oe,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_we,
    input  logic        bus_ready,
    input  logic [31:0] bus_rdata,
    input  logic        bus_valid,
    output logic        ovf_err
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        IREQ  = 3'd1,
        DREQ  = 3'd2,
        IWAIT = 3'd3,
        DWAIT = 3'd4
    } state_t;

    state_t           state_q, state_d;

    // Fetch FIFO: entry 0 is the head; the head stays until its read completes.
    logic [1:0][31:0] fifo_addr_q, fifo_addr_d;
    logic [1:0]       fifo_cnt_q, fifo_cnt_d;
    logic             fifo_full, fifo_push, fifo_pop;

    logic             slot_vld_q, slot_vld_d;
    logic [31:0]      slot_addr_q, slot_addr_d;
    logic [3:0]       slot_oe_q, slot_oe_d;
    logic [31:0]      slot_wdata_q, slot_wdata_d;
    logic [3:0]       slot_we_q, slot_we_d;
    logic             slot_load, slot_free;

    logic [31:0]      bus_addr_q, bus_addr_d;
    logic [3:0]       bus_oe_q, bus_oe_d;
    logic [31:0]      bus_wdata_q, bus_wdata_d;
    logic [3:0]       bus_we_q, bus_we_d;

    logic [31:0]      imem_rdata_q, imem_rdata_d;
    logic             imem_valid_q, imem_valid_d;
    logic [31:0]      mem_rdata_q, mem_rdata_d;
    logic             mem_valid_q, mem_valid_d;
    logic             ovf_err_q, ovf_err_d;

    logic             i_pend, d_pend, grant_i, grant_d;

`ifdef MEMARB_RR_EN
    // 0: instruction side wins the next conflict, 1: data side wins it
    logic             rr_ptr_q, rr_ptr_d;
`endif

    assign i_pend    = (fifo_cnt_q != 2'd0);
    assign d_pend    = slot_vld_q;
    assign fifo_full = (fifo_cnt_q == 2'd2);
    assign mem_ready = ~slot_vld_q & ~((state_q == DREQ) | (state_q == DWAIT));

    // Arbitration, bus sequencing and response capture
    always_comb begin
        state_d      = state_q;
        bus_addr_d   = bus_addr_q;
        bus_oe_d     = bus_oe_q;
        bus_wdata_d  = bus_wdata_q;
        bus_we_d     = bus_we_q;
        imem_rdata_d = imem_rdata_q;
        mem_rdata_d  = mem_rdata_q;
        imem_valid_d = 1'b0;
        mem_valid_d  = 1'b0;
        fifo_pop     = 1'b0;
        slot_free    = 1'b0;
        grant_i      = 1'b0;
        grant_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_pend && d_pend) begin
`ifdef MEMARB_RR_EN
                    grant_d = rr_ptr_q;
                    grant_i = ~rr_ptr_q;
`else
                    grant_d = 1'b1;
`endif
                end else begin
                    grant_i = i_pend;
                    grant_d = d_pend;
                end
                if (grant_i) begin
                    state_d     = IREQ;
                    bus_addr_d  = fifo_addr_q[0];
                    bus_oe_d    = 4'hF;
                    bus_wdata_d = 32'h0;
                    bus_we_d    = 4'h0;
                end else if (grant_d) begin
                    state_d     = DREQ;
                    bus_addr_d  = slot_addr_q;
                    bus_oe_d    = slot_oe_q;
                    bus_wdata_d = slot_wdata_q;
                    bus_we_d    = slot_we_q;
                end
            end
            IREQ: begin
                if (bus_ready) begin
                    bus_oe_d = 4'h0;
                    bus_we_d = 4'h0;
                    state_d  = IWAIT;
                end
            end
            DREQ: begin
                if (bus_ready) begin
                    bus_oe_d = 4'h0;
                    bus_we_d = 4'h0;
                    if (slot_we_q != 4'h0) begin
                        slot_free = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        state_d = DWAIT;
                    end
                end
            end
            IWAIT: begin
                if (bus_valid) begin
                    imem_rdata_d = bus_rdata;
                    imem_valid_d = 1'b1;
                    fifo_pop     = 1'b1;
                    state_d      = IDLE;
                end
            end
            DWAIT: begin
                if (bus_valid) begin
                    mem_rdata_d = bus_rdata;
                    mem_valid_d = 1'b1;
                    slot_free   = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef MEMARB_RR_EN
    // Pointer moves to the opposite side after every grant
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (grant_i) begin
            rr_ptr_d = 1'b1;
        end else if (grant_d) begin
            rr_ptr_d = 1'b0;
        end
    end
`endif

    // Fetch FIFO update; a pop in the same cycle frees room for a push
    always_comb begin
        fifo_addr_d = fifo_addr_q;
        fifo_cnt_d  = fifo_cnt_q;
        fifo_push   = imem_oe & (~fifo_full | fifo_pop);
        ovf_err_d   = ovf_err_q | (imem_oe & fifo_full & ~fifo_pop);
        if (fifo_pop) begin
            fifo_addr_d[0] = fifo_addr_q[1];
            fifo_cnt_d     = fifo_cnt_q - 2'd1;
        end
        if (fifo_push) begin
            fifo_addr_d[fifo_cnt_d[0]] = imem_addr;
            fifo_cnt_d                 = fifo_cnt_d + 2'd1;
        end
    end

    // Data slot capture and release
    always_comb begin
        slot_load    = (mem_oe != 4'h0) & mem_ready;
        slot_vld_d   = slot_vld_q;
        slot_addr_d  = slot_addr_q;
        slot_oe_d    = slot_oe_q;
        slot_wdata_d = slot_wdata_q;
        slot_we_d    = slot_we_q;
        if (slot_free) begin
            slot_vld_d = 1'b0;
        end
        if (slot_load) begin
            slot_vld_d   = 1'b1;
            slot_addr_d  = mem_addr;
            slot_oe_d    = mem_oe;
            slot_wdata_d = mem_wdata;
            slot_we_d    = mem_we;
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            fifo_addr_q  <= '0;
            fifo_cnt_q   <= 2'd0;
            slot_vld_q   <= 1'b0;
            slot_addr_q  <= 32'h0;
            slot_oe_q    <= 4'h0;
            slot_wdata_q <= 32'h0;
            slot_we_q    <= 4'h0;
            bus_addr_q   <= BOOT_ADDR;
            bus_oe_q     <= 4'h0;
            bus_wdata_q  <= 32'h0;
            bus_we_q     <= 4'h0;
            imem_rdata_q <= 32'h0;
            imem_valid_q <= 1'b0;
            mem_rdata_q  <= 32'h0;
            mem_valid_q  <= 1'b0;
            ovf_err_q    <= 1'b0;
`ifdef MEMARB_RR_EN
            rr_ptr_q     <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            fifo_addr_q  <= fifo_addr_d;
            fifo_cnt_q   <= fifo_cnt_d;
            slot_vld_q   <= slot_vld_d;
            slot_addr_q  <= slot_addr_d;
            slot_oe_q    <= slot_oe_d;
            slot_wdata_q <= slot_wdata_d;
            slot_we_q    <= slot_we_d;
            bus_addr_q   <= bus_addr_d;
            bus_oe_q     <= bus_oe_d;
            bus_wdata_q  <= bus_wdata_d;
            bus_we_q     <= bus_we_d;
            imem_rdata_q <= imem_rdata_d;
            imem_valid_q <= imem_valid_d;
            mem_rdata_q  <= mem_rdata_d;
            mem_valid_q  <= mem_valid_d;
            ovf_err_q    <= ovf_err_d;
`ifdef MEMARB_RR_EN
            rr_ptr_q     <= rr_ptr_d;
`endif
        end
    end

    assign imem_rdata = imem_rdata_q;
    assign imem_valid = imem_valid_q;
    assign mem_rdata  = mem_rdata_q;
    assign mem_valid  = mem_valid_q;
    assign bus_addr   = bus_addr_q;
    assign bus_oe     = bus_oe_q;
    assign bus_wdata  = bus_wdata_q;
    assign bus_we     = bus_we_q;
    assign ovf_err    = ovf_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed scenarios followed by a randomized run
// against a transaction-level model (in-order response queues, a word memory
// for the data side, and a fetch-occupancy count for overflow prediction).
module tb_mem_arbiter;
    localparam logic [31:0] BOOT = 32'h0000_0ABC;
`ifdef MEMARB_RR_EN
    localparam bit DATA_FIRST = 1'b0;
`else
    localparam bit DATA_FIRST = 1'b1;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem_addr, imem_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        imem_oe, imem_valid, mem_valid, mem_ready;
    logic [3:0]  mem_oe, mem_we, bus_oe, bus_we;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic        bus_ready, bus_valid, ovf_err;

    mem_arbiter #(.BOOT_ADDR(BOOT)) dut (
        .clk(clk), .rst(rst),
        .imem_addr(imem_addr), .imem_oe(imem_oe), .imem_rdata(imem_rdata), .imem_valid(imem_valid),
        .mem_addr(mem_addr), .mem_oe(mem_oe), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata), .mem_valid(mem_valid), .mem_ready(mem_ready),
        .bus_addr(bus_addr), .bus_oe(bus_oe), .bus_wdata(bus_wdata), .bus_we(bus_we),
        .bus_ready(bus_ready), .bus_rdata(bus_rdata), .bus_valid(bus_valid), .ovf_err(ovf_err)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    bit iv_seen, mv_seen;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        iv_seen |= imem_valid;
        mv_seen |= mem_valid;
    endtask

    task automatic idle_inputs();
        imem_oe = 1'b0; imem_addr = 32'h0;
        mem_oe = 4'h0; mem_we = 4'h0; mem_addr = 32'h0; mem_wdata = 32'h0;
        bus_ready = 1'b0; bus_valid = 1'b0; bus_rdata = 32'h0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        iv_seen = 1'b0;
        mv_seen = 1'b0;
    endtask

    // ---------------- reference model for the randomized run ----------------
    logic [31:0] exp_i[$];
    logic [31:0] exp_d[$];
    logic [31:0] model_mem[16];
    logic [31:0] bus_dmem[16];
    int          inst_cnt;
    bit          exp_ovf;
    bit          rd_pend, rd_isinstr;
    int          rd_cnt;
    logic [31:0] rd_data;

    function automatic logic [31:0] ifetch(input logic [31:0] a);
        return a ^ 32'h1F2E_3D4C;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (be[b]) r[b*8 +: 8] = nw[b*8 +: 8];
        return r;
    endfunction

    task automatic rand_step(input bit allow);
        bit pop_i;
        int idx;
        if (imem_valid) begin
            if (exp_i.size() == 0) check("i_unexpected", 32'd1, 32'd0);
            else check("i_rdata", imem_rdata, exp_i.pop_front());
        end
        if (mem_valid) begin
            if (exp_d.size() == 0) check("d_unexpected", 32'd1, 32'd0);
            else check("d_rdata", mem_rdata, exp_d.pop_front());
        end
        // backend responder
        pop_i = 1'b0;
        bus_valid = 1'b0;
        bus_rdata = $urandom;
        if (rd_pend) begin
            if (rd_cnt == 0) begin
                bus_valid = 1'b1;
                bus_rdata = rd_data;
                rd_pend   = 1'b0;
                pop_i     = rd_isinstr;
            end else begin
                rd_cnt--;
            end
        end else if ($urandom_range(0, 7) == 0) begin
            bus_valid = 1'b1;
        end
        bus_ready = allow ? ($urandom_range(0, 9) < 6) : 1'b1;
        if (bus_oe != 4'h0 && bus_ready) begin
            if (bus_we != 4'h0) begin
                bus_dmem[bus_addr[5:2]] = merge(bus_dmem[bus_addr[5:2]], bus_wdata, bus_we);
            end else begin
                rd_pend    = 1'b1;
                rd_cnt     = $urandom_range(0, 2);
                rd_isinstr = (bus_addr[15:12] == 4'h1);
                rd_data    = rd_isinstr ? ifetch(bus_addr) : bus_dmem[bus_addr[5:2]];
            end
        end
        // instruction requests
        imem_oe = 1'b0;
        if (allow && $urandom_range(0, 9) < 4) begin
            imem_oe   = 1'b1;
            imem_addr = 32'h1000 + ($urandom_range(0, 63) << 2);
            if (inst_cnt == 2 && !pop_i) begin
                exp_ovf = 1'b1;
            end else begin
                exp_i.push_back(ifetch(imem_addr));
                inst_cnt++;
            end
        end
        if (pop_i) inst_cnt--;
        // data requests (also driven while not ready, which must be ignored)
        mem_oe = 4'h0;
        mem_we = 4'h0;
        if (allow && $urandom_range(0, 9) < 4) begin
            idx       = $urandom_range(0, 15);
            mem_addr  = 32'h8000 + (idx << 2);
            mem_wdata = $urandom;
            mem_oe    = 4'($urandom_range(1, 15));
            mem_we    = $urandom_range(0, 1) ? 4'($urandom_range(1, 15)) : 4'h0;
            if (mem_ready) begin
                if (mem_we != 4'h0) model_mem[idx] = merge(model_mem[idx], mem_wdata, mem_we);
                else exp_d.push_back(model_mem[idx]);
            end
        end
        tick();
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();

        // reset values
        do_reset();
        check("rst_bus_addr", bus_addr, BOOT);
        check("rst_bus_oe", 32'(bus_oe), 32'h0);
        check("rst_bus_we", 32'(bus_we), 32'h0);
        check("rst_bus_wdata", bus_wdata, 32'h0);
        check("rst_imem_rdata", imem_rdata, 32'h0);
        check("rst_mem_rdata", mem_rdata, 32'h0);
        check("rst_valids", 32'({imem_valid, mem_valid}), 32'h0);
        check("rst_ovf", 32'(ovf_err), 32'h0);
        check("rst_mem_ready", 32'(mem_ready), 32'h1);

        // single fetch
        imem_oe = 1'b1; imem_addr = 32'h100; bus_ready = 1'b1;
        tick();                                                    // c1
        imem_oe = 1'b0;
        check("sf_oe_c1", 32'(bus_oe), 32'h0);
        tick();                                                    // c2
        check("sf_oe_c2", 32'(bus_oe), 32'hF);
        check("sf_addr_c2", bus_addr, 32'h100);
        tick();                                                    // c3
        check("sf_oe_c3", 32'(bus_oe), 32'h0);
        tick();                                                    // c4
        bus_valid = 1'b1; bus_rdata = 32'hDEAD_BEEF;
        check("sf_early_valid", 32'(iv_seen), 32'h0);
        tick();                                                    // c5
        bus_valid = 1'b0;
        check("sf_valid_c5", 32'(imem_valid), 32'h1);
        check("sf_rdata_c5", imem_rdata, 32'hDEAD_BEEF);
        tick();                                                    // c6
        check("sf_valid_c6", 32'(imem_valid), 32'h0);
        check("sf_rdata_hold", imem_rdata, 32'hDEAD_BEEF);

        // conflict between sides
        do_reset();
        imem_oe = 1'b1; imem_addr = 32'h200;
        mem_oe = 4'hF; mem_we = 4'h0; mem_addr = 32'h3000; bus_ready = 1'b1;
        tick();                                                    // c1
        imem_oe = 1'b0; mem_oe = 4'h0;
        tick();                                                    // c2
        check("cf_first_addr", bus_addr, DATA_FIRST ? 32'h3000 : 32'h200);
        check("cf_first_oe", 32'(bus_oe), 32'hF);
        tick();                                                    // c3
        bus_valid = 1'b1; bus_rdata = 32'h1111_1111;
        tick();                                                    // c4
        bus_valid = 1'b0;
        check("cf_first_valid", 32'(DATA_FIRST ? mem_valid : imem_valid), 32'h1);
        check("cf_first_rdata", DATA_FIRST ? mem_rdata : imem_rdata, 32'h1111_1111);
        check("cf_gap_oe", 32'(bus_oe), 32'h0);
        tick();                                                    // c5
        check("cf_second_addr", bus_addr, DATA_FIRST ? 32'h200 : 32'h3000);
        check("cf_second_oe", 32'(bus_oe), 32'hF);
        tick();                                                    // c6
        bus_valid = 1'b1; bus_rdata = 32'h2222_2222;
        tick();                                                    // c7
        bus_valid = 1'b0;
        check("cf_second_valid", 32'(DATA_FIRST ? imem_valid : mem_valid), 32'h1);
        check("cf_second_rdata", DATA_FIRST ? imem_rdata : mem_rdata, 32'h2222_2222);

        // store with backpressure
        do_reset();
        mem_oe = 4'h3; mem_we = 4'h3; mem_addr = 32'h40; mem_wdata = 32'hCAFE_1234;
        tick();                                                    // c1
        mem_oe = 4'h0; mem_we = 4'h0;
        check("st_ready_c1", 32'(mem_ready), 32'h0);
        tick();                                                    // c2
        for (int c = 2; c <= 4; c++) begin
            check("st_addr", bus_addr, 32'h40);
            check("st_oe", 32'(bus_oe), 32'h3);
            check("st_we", 32'(bus_we), 32'h3);
            check("st_wdata", bus_wdata, 32'hCAFE_1234);
            check("st_ready_hold", 32'(mem_ready), 32'h0);
            tick();
        end
        bus_ready = 1'b1;                                          // c5
        check("st_ready_c5", 32'(mem_ready), 32'h0);
        tick();                                                    // c6
        bus_ready = 1'b0;
        check("st_ready_after", 32'(mem_ready), 32'h1);
        check("st_oe_clear", 32'(bus_oe), 32'h0);
        check("st_we_clear", 32'(bus_we), 32'h0);
        tick();
        tick();
        check("st_no_mem_valid", 32'(mv_seen), 32'h0);

        // fetch FIFO overflow
        do_reset();
        imem_oe = 1'b1; imem_addr = 32'h500;
        tick();                                                    // c1
        imem_addr = 32'h504;
        tick();                                                    // c2
        imem_addr = 32'h508;
        check("of_addr_c2", bus_addr, 32'h500);
        tick();                                                    // c3
        imem_oe = 1'b0;
        check("of_ovf_set", 32'(ovf_err), 32'h1);
        tick();                                                    // c4
        tick();                                                    // c5
        bus_ready = 1'b1;
        tick();                                                    // c6
        check("of_oe_c6", 32'(bus_oe), 32'h0);
        tick();                                                    // c7
        bus_valid = 1'b1; bus_rdata = 32'hAAAA_0500;
        tick();                                                    // c8
        bus_valid = 1'b0;
        check("of_first_valid", 32'(imem_valid), 32'h1);
        check("of_first_rdata", imem_rdata, 32'hAAAA_0500);
        tick();                                                    // c9
        check("of_second_addr", bus_addr, 32'h504);
        check("of_second_oe", 32'(bus_oe), 32'hF);
        tick();                                                    // c10
        tick();                                                    // c11
        bus_valid = 1'b1; bus_rdata = 32'hBBBB_0504;
        tick();                                                    // c12
        bus_valid = 1'b0;
        check("of_second_valid", 32'(imem_valid), 32'h1);
        check("of_second_rdata", imem_rdata, 32'hBBBB_0504);
        tick();
        tick();                                                    // c14
        check("of_no_third_oe", 32'(bus_oe), 32'h0);
        check("of_no_third_addr", bus_addr, 32'h504);
        check("of_ovf_sticky", 32'(ovf_err), 32'h1);

        // reset during a data read wait
        do_reset();
        mem_oe = 4'hF; mem_we = 4'h0; mem_addr = 32'h80; bus_ready = 1'b1;
        tick();                                                    // c1
        mem_oe = 4'h0;
        tick();                                                    // c2
        tick();                                                    // c3
        bus_ready = 1'b0; rst = 1'b1;
        tick();                                                    // c4
        rst = 1'b0;
        check("rd_ready_c4", 32'(mem_ready), 32'h1);
        check("rd_oe_c4", 32'(bus_oe), 32'h0);
        tick();                                                    // c5
        bus_valid = 1'b1; bus_rdata = 32'h7777_7777;
        tick();                                                    // c6
        bus_valid = 1'b0;
        tick();
        tick();
        tick();                                                    // c9
        check("rd_no_mem_valid", 32'(mv_seen), 32'h0);
        check("rd_mem_rdata", mem_rdata, 32'h0);
        check("rd_ready_c9", 32'(mem_ready), 32'h1);
        check("rd_oe_c9", 32'(bus_oe), 32'h0);

        // randomized traffic against the model
        do_reset();
        for (int i = 0; i < 16; i++) begin
            model_mem[i] = 32'h5000_0000 + 32'(i) * 32'h0101_0101;
            bus_dmem[i]  = model_mem[i];
        end
        inst_cnt = 0; exp_ovf = 1'b0; rd_pend = 1'b0; rd_cnt = 0;
        for (int k = 0; k < 3000; k++) rand_step(1'b1);
        begin
            bit done;
            done = 1'b0;
            for (int k = 0; k < 400 && !done; k++) begin
                rand_step(1'b0);
                done = (exp_i.size() == 0) && (exp_d.size() == 0) && !rd_pend && (inst_cnt == 0);
            end
            check("rnd_drained", 32'(done), 32'h1);
        end
        check("rnd_ovf", 32'(ovf_err), 32'(exp_ovf));
        check("rnd_mem_ready", 32'(mem_ready), 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
